// File: rtl/sdram_pattern_if.sv
// sdram_pattern_if: request/acknowledge access bus between the pattern tester and sdram_top.
//   wr_req/rd_req  request, held high until the matching ack
//   wr_ack/rd_ack  one-cycle acknowledge; rd_data valid with rd_ack
//   wr_addr/rd_addr/wr_data/rd_data  access address and data words
//   burst_len      access length, constant single-word bursts
interface sdram_pattern_if #(
   parameter int unsigned ADDR_W = 24,
   parameter int unsigned DATA_W = 16
);
   logic              wr_req;
   logic              wr_ack;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              rd_req;
   logic              rd_ack;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic [8:0]        burst_len;

   // Tester side
   modport master (
      output wr_req, wr_addr, wr_data, rd_req, rd_addr, burst_len,
      input  wr_ack, rd_ack, rd_data
   );

   // SDRAM controller side
   modport slave (
      input  wr_req, wr_addr, wr_data, rd_req, rd_addr, burst_len,
      output wr_ack, rd_ack, rd_data
   );
endinterface

// File: rtl/sdram_pattern_tester.sv
// sdram_pattern_tester: repeating SDRAM write/readback self-test.
// Each pass writes NUM_WORDS words from BASE_ADDR, reads them back, compares and
// counts mismatches and ack timeouts; status goes to LEDs and a muxed hex display.
// Optional feature macro: SDRAM_TEST_LFSR_EN selects a 16-bit Galois LFSR word
// sequence (needs DATA_W=16); undefined gives the incrementing seed+idx pattern.
// Ports:
//   clock_50m, reset_n  clock, async active-low reset
//   init_done           SDRAM initialisation complete
//   bus                 sdram_pattern_if master (req/ack access bus, burst_len=1)
//   pass_count          completed passes (wraps)
//   err_count           mismatches + timeouts (saturates)
//   fail, led_ok        sticky error flag, init_done & ~fail
//   sel, seg            active-low digit select and {dp,g..a} segments
module sdram_pattern_tester #(
   parameter int unsigned       DATA_W    = 16,
   parameter int unsigned       ADDR_W    = 24,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
   parameter int unsigned       NUM_WORDS = 256,
   parameter int unsigned       PASS_GAP  = 25000000,
   parameter int unsigned       TIMEOUT   = 4096,
   parameter int unsigned       DIGITS    = 4,
   parameter int unsigned       SCAN_BITS = 10
) (
   input  logic            clock_50m,
   input  logic            reset_n,
   input  logic            init_done,
   sdram_pattern_if.master bus,
   output logic [15:0]     pass_count,
   output logic [15:0]     err_count,
   output logic            fail,
   output logic            led_ok,
   output logic [7:0]      sel,
   output logic [7:0]      seg
);

   localparam int unsigned IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
   localparam int unsigned TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam int unsigned PRE_W = SCAN_BITS - 2;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_WORDS - 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {S_INIT, S_WR, S_RD, S_GAP} state_t;

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic              wr_req_q, wr_req_d;
   logic              rd_req_q, rd_req_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wr_data_q, wr_data_d;
   logic [DATA_W-1:0] seed_q, seed_d;
   logic [DATA_W-1:0] pat_q, pat_d;
   logic [TMO_W-1:0]  tmo_q, tmo_d;
   logic [31:0]       gap_q, gap_d;
   logic [15:0]       pass_d, err_d;
   logic              fail_d;
   logic              err_hit;
   logic              req_c, ack_c;
   logic [DATA_W-1:0] pat_seed_c, pat_next_c;

   assign bus.wr_req    = wr_req_q;
   assign bus.rd_req    = rd_req_q;
   assign bus.wr_addr   = addr_q;
   assign bus.rd_addr   = addr_q;
   assign bus.wr_data   = wr_data_q;
   assign bus.burst_len = 9'd1;

   // Only an ack matching the currently raised request counts
   assign req_c = wr_req_q | rd_req_q;
   assign ack_c = (wr_req_q & bus.wr_ack) | (rd_req_q & bus.rd_ack);

   // pat_q always holds the expected word for the current idx
`ifdef SDRAM_TEST_LFSR_EN
   logic [15:0] lfsr_seed_c, lfsr_next_c;
   assign lfsr_seed_c = ((16'(seed_q) ^ 16'hACE1) == 16'h0000) ? 16'hACE1
                                                               : (16'(seed_q) ^ 16'hACE1);
   // Right-shift Galois form of x^16+x^14+x^13+x^11+1
   assign lfsr_next_c = {1'b0, pat_q[15:1]} ^ (pat_q[0] ? 16'hB400 : 16'h0000);
   assign pat_seed_c  = DATA_W'(lfsr_seed_c);
   assign pat_next_c  = DATA_W'(lfsr_next_c);
`else
   assign pat_seed_c  = seed_q;
   assign pat_next_c  = pat_q + DATA_W'(1);
`endif

   // Test sequencer state register
   always_ff @(posedge clock_50m or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_INIT;
         idx_q      <= '0;
         wr_req_q   <= 1'b0;
         rd_req_q   <= 1'b0;
         addr_q     <= '0;
         wr_data_q  <= '0;
         seed_q     <= '0;
         pat_q      <= '0;
         tmo_q      <= '0;
         gap_q      <= '0;
         pass_count <= '0;
         err_count  <= '0;
         fail       <= 1'b0;
         led_ok     <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         wr_req_q   <= wr_req_d;
         rd_req_q   <= rd_req_d;
         addr_q     <= addr_d;
         wr_data_q  <= wr_data_d;
         seed_q     <= seed_d;
         pat_q      <= pat_d;
         tmo_q      <= tmo_d;
         gap_q      <= gap_d;
         pass_count <= pass_d;
         err_count  <= err_d;
         fail       <= fail_d;
         led_ok     <= init_done & ~fail_d;
      end
   end

   // Test sequencer next state and register updates
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      wr_req_d  = wr_req_q;
      rd_req_d  = rd_req_q;
      addr_d    = addr_q;
      wr_data_d = wr_data_q;
      seed_d    = seed_q;
      pat_d     = pat_q;
      tmo_d     = tmo_q;
      gap_d     = gap_q;
      pass_d    = pass_count;
      err_hit   = 1'b0;

      if (state_q != S_INIT && !init_done) begin
         // Controller fell out of init: abandon the pass, keep counters
         state_d  = S_INIT;
         wr_req_d = 1'b0;
         rd_req_d = 1'b0;
         idx_d    = '0;
      end else begin
         case (state_q)
            S_INIT: begin
               if (init_done) begin
                  state_d = S_WR;
                  idx_d   = '0;
                  pat_d   = pat_seed_c;
               end
            end
            S_WR, S_RD: begin
               if (!req_c) begin
                  // Launch next access; address/data registered with the request
                  wr_req_d = (state_q == S_WR);
                  rd_req_d = (state_q == S_RD);
                  addr_d   = BASE_ADDR + ADDR_W'(idx_q);
                  tmo_d    = '0;
                  if (state_q == S_WR) begin
                     wr_data_d = pat_q;
                  end
               end else if (ack_c) begin
                  wr_req_d = 1'b0;
                  rd_req_d = 1'b0;
                  pat_d    = pat_next_c;
                  if (state_q == S_RD && bus.rd_data != pat_q) begin
                     err_hit = 1'b1;
                  end
                  if (idx_q == IDX_LAST) begin
                     idx_d = '0;
                     if (state_q == S_WR) begin
                        state_d = S_RD;
                        pat_d   = pat_seed_c;
                     end else begin
                        state_d = S_GAP;
                        gap_d   = '0;
                        pass_d  = pass_count + 16'd1;
                        seed_d  = seed_q + DATA_W'(1);
                     end
                  end else begin
                     idx_d = idx_q + IDX_W'(1);
                  end
               end else if (tmo_q == TMO_LAST) begin
                  // No ack in time: abort pass, seed and pass_count untouched
                  wr_req_d = 1'b0;
                  rd_req_d = 1'b0;
                  err_hit  = 1'b1;
                  state_d  = S_GAP;
                  gap_d    = '0;
                  idx_d    = '0;
               end else begin
                  tmo_d = tmo_q + TMO_W'(1);
               end
            end
            S_GAP: begin
               if ((gap_q + 32'd1) >= PASS_GAP) begin
                  state_d = S_WR;
                  idx_d   = '0;
                  pat_d   = pat_seed_c;
               end else begin
                  gap_d = gap_q + 32'd1;
               end
            end
            default: state_d = S_INIT;
         endcase
      end

      err_d  = (err_hit && err_count != 16'hFFFF) ? err_count + 16'd1 : err_count;
      fail_d = fail | err_hit;
   end

   // Display scan: prescaler tick advances digit; sel/seg loaded together
   logic [PRE_W-1:0] pre_q;
   logic [2:0]       digit_q;
   logic [31:0]      err_ext;
   logic [3:0]       nib_c;
   logic [6:0]       hex_c;

   assign err_ext = 32'(err_count);
   assign nib_c   = err_ext[{digit_q, 2'b00} +: 4];

   // Hex to active-high gfedcba
   always_comb begin
      hex_c = 7'h00;
      case (nib_c)
         4'h0: hex_c = 7'h3F;
         4'h1: hex_c = 7'h06;
         4'h2: hex_c = 7'h5B;
         4'h3: hex_c = 7'h4F;
         4'h4: hex_c = 7'h66;
         4'h5: hex_c = 7'h6D;
         4'h6: hex_c = 7'h7D;
         4'h7: hex_c = 7'h07;
         4'h8: hex_c = 7'h7F;
         4'h9: hex_c = 7'h6F;
         4'hA: hex_c = 7'h77;
         4'hB: hex_c = 7'h7C;
         4'hC: hex_c = 7'h39;
         4'hD: hex_c = 7'h5E;
         4'hE: hex_c = 7'h79;
         default: hex_c = 7'h71;
      endcase
   end

   // Digit multiplexer registers
   always_ff @(posedge clock_50m or negedge reset_n) begin
      if (!reset_n) begin
         pre_q   <= '0;
         digit_q <= '0;
         sel     <= 8'hFF;
         seg     <= 8'hFF;
      end else begin
         pre_q <= pre_q + PRE_W'(1);
         if (&pre_q) begin
            sel     <= ~(8'd1 << digit_q);
            seg     <= {1'b1, ~hex_c};
            digit_q <= (digit_q == 3'(DIGITS - 1)) ? 3'd0 : digit_q + 3'd1;
         end
      end
   end

endmodule

// File: tb/tb_sdram_pattern_tester.sv
// tb_sdram_pattern_tester: directed bench for sdram_pattern_tester with a small
// SDRAM model (ack three cycles after a request, optional read bit flip at
// address 0, optional refusal to ack a write to 24'hFFFFFF).
module tb_sdram_pattern_tester;

   logic        clock_50m = 1'b0;
   logic        reset_n   = 1'b0;
   logic        init_done = 1'b0;
   logic [15:0] pass_count, err_count;
   logic        fail, led_ok;
   logic [7:0]  sel, seg;

   sdram_pattern_if #(.ADDR_W(24), .DATA_W(16)) bus ();

   sdram_pattern_tester #(
      .DATA_W(16), .ADDR_W(24), .BASE_ADDR(24'hFFFFFE), .NUM_WORDS(4),
      .PASS_GAP(8), .TIMEOUT(16), .DIGITS(4), .SCAN_BITS(4)
   ) dut (
      .clock_50m (clock_50m),
      .reset_n   (reset_n),
      .init_done (init_done),
      .bus       (bus),
      .pass_count(pass_count),
      .err_count (err_count),
      .fail      (fail),
      .led_ok    (led_ok),
      .sel       (sel),
      .seg       (seg)
   );

   always #10 clock_50m = ~clock_50m;

   int checks = 0;
   int passes = 0;
   int restart_base = 0;

   // Model controls and logs
   logic        flip_rd  = 1'b0;
   logic        block_wr = 1'b0;
   logic        overlap  = 1'b0;
   logic        gap_viol = 1'b0;
   logic        ack_seen = 1'b0;
   int          lat = 0;
   int          wcnt = 0;
   int          rcnt = 0;
   logic [15:0] mem [0:7];
   logic [23:0] wlog_addr [0:255];
   logic [15:0] wlog_data [0:255];
   logic [23:0] rlog_addr [0:255];

   // SDRAM model and protocol monitor
   always @(posedge clock_50m or negedge reset_n) begin
      if (!reset_n) begin
         bus.wr_ack <= 1'b0;
         bus.rd_ack <= 1'b0;
         lat        <= 0;
         ack_seen   <= 1'b0;
      end else begin
         bus.wr_ack <= 1'b0;
         bus.rd_ack <= 1'b0;
         if (bus.wr_req && bus.rd_req) overlap <= 1'b1;
         if (ack_seen && (bus.wr_req || bus.rd_req)) gap_viol <= 1'b1;
         ack_seen <= bus.wr_ack | bus.rd_ack;
         if ((bus.wr_req || bus.rd_req) && !bus.wr_ack && !bus.rd_ack) begin
            if (lat < 2) begin
               lat <= lat + 1;
            end else if (bus.wr_req) begin
               if (!(block_wr && bus.wr_addr == 24'hFFFFFF)) begin
                  bus.wr_ack               <= 1'b1;
                  mem[bus.wr_addr[2:0]]    <= bus.wr_data;
                  wlog_addr[8'(wcnt)]      <= bus.wr_addr;
                  wlog_data[8'(wcnt)]      <= bus.wr_data;
                  wcnt                     <= wcnt + 1;
                  lat                      <= 0;
               end
            end else begin
               bus.rd_ack          <= 1'b1;
               bus.rd_data         <= mem[bus.rd_addr[2:0]] ^
                                      ((flip_rd && bus.rd_addr == 24'h000000) ? 16'h0001 : 16'h0000);
               rlog_addr[8'(rcnt)] <= bus.rd_addr;
               rcnt                <= rcnt + 1;
               lat                 <= 0;
            end
         end else begin
            lat <= 0;
         end
      end
   end

   // Expected word idx of a pass started with the given seed
   function automatic logic [15:0] exp_word(input logic [15:0] seed, input int idx);
`ifdef SDRAM_TEST_LFSR_EN
      logic [15:0] s;
      s = seed ^ 16'hACE1;
      if (s == 16'h0000) s = 16'hACE1;
      for (int i = 0; i < idx; i++) s = s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
      return s;
`else
      return seed + 16'(idx);
`endif
   endfunction

   task automatic cycles(input int n);
      repeat (n) @(negedge clock_50m);
   endtask

   task automatic wait_pass(input logic [15:0] target);
      int n;
      n = 0;
      while (pass_count !== target && n < 400) begin
         cycles(1);
         n++;
      end
   endtask

   task automatic test_reset;
      reset_n   = 1'b0;
      init_done = 1'b0;
      cycles(3);
      checks++;
      if ({bus.wr_req, bus.rd_req} !== 2'b00) $display("FAIL reset_req: got %b expected 00", {bus.wr_req, bus.rd_req});
      else passes++;
      checks++;
      if ({pass_count, err_count} !== 32'h0) $display("FAIL reset_counts: got %h expected 0", {pass_count, err_count});
      else passes++;
      checks++;
      if ({fail, led_ok} !== 2'b00) $display("FAIL reset_flags: got %b expected 00", {fail, led_ok});
      else passes++;
      checks++;
      if ({sel, seg} !== 16'hFFFF) $display("FAIL reset_display: got %h expected ffff", {sel, seg});
      else passes++;
      checks++;
      if (bus.burst_len !== 9'd1) $display("FAIL burst_len: got %0d expected 1", bus.burst_len);
      else passes++;
      reset_n = 1'b1;
      cycles(6);
      checks++;
      if (bus.wr_req !== 1'b0) $display("FAIL init_wait: wr_req got %b expected 0", bus.wr_req);
      else passes++;
   endtask

   task automatic test_basic_pass;
      int wb, rb;
      logic [23:0] ea [4];
      ea[0] = 24'hFFFFFE; ea[1] = 24'hFFFFFF; ea[2] = 24'h000000; ea[3] = 24'h000001;
      wb = wcnt;
      rb = rcnt;
      init_done = 1'b1;
      wait_pass(16'd1);
      checks++;
      if (pass_count !== 16'd1) $display("FAIL pass1: pass_count got %0d expected 1", pass_count);
      else passes++;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (wlog_addr[wb + i] !== ea[i] || wlog_data[wb + i] !== exp_word(16'd0, i))
            $display("FAIL pass1_write%0d: got %h/%h expected %h/%h", i, wlog_addr[wb + i], wlog_data[wb + i], ea[i], exp_word(16'd0, i));
         else passes++;
         checks++;
         if (rlog_addr[rb + i] !== ea[i]) $display("FAIL pass1_read%0d: addr got %h expected %h", i, rlog_addr[rb + i], ea[i]);
         else passes++;
      end
      checks++;
      if ({err_count, fail, led_ok} !== {16'h0, 1'b0, 1'b1})
         $display("FAIL pass1_status: err/fail/led got %h/%b/%b expected 0/0/1", err_count, fail, led_ok);
      else passes++;
      wait_pass(16'd2);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (wlog_data[wb + 4 + i] !== exp_word(16'd1, i))
            $display("FAIL pass2_write%0d: got %h expected %h", i, wlog_data[wb + 4 + i], exp_word(16'd1, i));
         else passes++;
      end
   endtask

   task automatic test_compare_error;
      int n;
      flip_rd = 1'b1;
      wait_pass(16'd3);
      flip_rd = 1'b0;
      checks++;
      if ({err_count, fail, led_ok} !== {16'd1, 1'b1, 1'b0})
         $display("FAIL flip_status: err/fail/led got %h/%b/%b expected 1/1/0", err_count, fail, led_ok);
      else passes++;
      wait_pass(16'd4);
      checks++;
      if ({pass_count, err_count, fail} !== {16'd4, 16'd1, 1'b1})
         $display("FAIL sticky: pass/err/fail got %0d/%0d/%b expected 4/1/1", pass_count, err_count, fail);
      else passes++;
      n = 0;
      while (sel !== 8'hFE && n < 40) begin cycles(1); n++; end
      checks++;
      if (sel !== 8'hFE || seg !== 8'hF9) $display("FAIL digit0: sel/seg got %h/%h expected fe/f9", sel, seg);
      else passes++;
      n = 0;
      while (sel !== 8'hFD && n < 40) begin cycles(1); n++; end
      checks++;
      if (sel !== 8'hFD || seg !== 8'hC0) $display("FAIL digit1: sel/seg got %h/%h expected fd/c0", sel, seg);
      else passes++;
   endtask

   task automatic test_timeout;
      int n, wb;
      block_wr = 1'b1;
      n = 0;
      while (!(bus.wr_req === 1'b1 && bus.wr_addr === 24'hFFFFFF) && n < 300) begin cycles(1); n++; end
      n = 0;
      while (bus.wr_req === 1'b1 && n < 100) begin n++; cycles(1); end
      block_wr = 1'b0;
      checks++;
      if (n !== 16) $display("FAIL timeout_len: wr_req high %0d cycles expected 16", n);
      else passes++;
      checks++;
      if ({err_count, pass_count} !== {16'd2, 16'd4})
         $display("FAIL timeout_counts: err/pass got %0d/%0d expected 2/4", err_count, pass_count);
      else passes++;
      wb = wcnt;
      n = 0;
      while (wcnt <= wb && n < 100) begin cycles(1); n++; end
      checks++;
      if (wlog_addr[wb] !== 24'hFFFFFE || wlog_data[wb] !== exp_word(16'd4, 0))
         $display("FAIL timeout_restart: got %h/%h expected fffffe/%h", wlog_addr[wb], wlog_data[wb], exp_word(16'd4, 0));
      else passes++;
      wait_pass(16'd5);
      checks++;
      if ({pass_count, err_count} !== {16'd5, 16'd2})
         $display("FAIL after_timeout: pass/err got %0d/%0d expected 5/2", pass_count, err_count);
      else passes++;
   endtask

   task automatic test_init_drop;
      int n;
      n = 0;
      while (bus.wr_req !== 1'b1 && n < 100) begin cycles(1); n++; end
      init_done = 1'b0;
      cycles(1);
      checks++;
      if ({bus.wr_req, bus.rd_req, led_ok} !== 3'b000 || {pass_count, err_count} !== {16'd5, 16'd2})
         $display("FAIL init_drop: req/led got %b pass/err %0d/%0d expected 000 5/2", {bus.wr_req, bus.rd_req, led_ok}, pass_count, err_count);
      else passes++;
      cycles(5);
      init_done = 1'b1;
      wait_pass(16'd6);
      checks++;
      if ({pass_count, err_count} !== {16'd6, 16'd2})
         $display("FAIL init_resume: pass/err got %0d/%0d expected 6/2", pass_count, err_count);
      else passes++;
   endtask

   task automatic test_reset_mid_read;
      int n;
      n = 0;
      while (bus.rd_req !== 1'b1 && n < 200) begin cycles(1); n++; end
      reset_n = 1'b0;
      #1;
      checks++;
      if ({bus.rd_req, sel} !== {1'b0, 8'hFF} || {pass_count, err_count, fail} !== 33'h0)
         $display("FAIL reset_mid_read: rd_req/sel got %b/%h pass/err/fail %0d/%0d/%b expected 0/ff 0/0/0", bus.rd_req, sel, pass_count, err_count, fail);
      else passes++;
      cycles(2);
      restart_base = wcnt;
      reset_n = 1'b1;
      wait_pass(16'd1);
      checks++;
      if (wlog_addr[restart_base] !== 24'hFFFFFE || wlog_data[restart_base] !== exp_word(16'd0, 0) || err_count !== 16'd0)
         $display("FAIL reset_restart: got %h/%h err %0d expected fffffe/%h err 0", wlog_addr[restart_base], wlog_data[restart_base], err_count, exp_word(16'd0, 0));
      else passes++;
   endtask

   task automatic test_lfsr(input int base);
      checks++;
      if (wlog_data[base] !== 16'hACE1 || wlog_data[base + 1] !== 16'hE270 || err_count !== 16'd0)
         $display("FAIL lfsr_words: got %h %h err %0d expected ace1 e270 err 0", wlog_data[base], wlog_data[base + 1], err_count);
      else passes++;
   endtask

   task automatic test_protocol;
      checks++;
      if ({overlap, gap_viol} !== 2'b00) $display("FAIL protocol: overlap/no-gap got %b expected 00", {overlap, gap_viol});
      else passes++;
   endtask

   initial begin
      test_reset();
      test_basic_pass();
      test_compare_error();
      test_timeout();
      test_init_drop();
      test_reset_mid_read();
`ifdef SDRAM_TEST_LFSR_EN
      test_lfsr(restart_base);
`endif
      test_protocol();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
